regfile_write_buffer: RTL

- Writer-side companion to the pipeline register file.
- Accepts writeback requests through a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains at most one entry per clock onto the register file write port (regWrite / writeRegister / writeData).
- Provides combinational forwarding lookups so decode can see values still pending in the buffer.

---
 rtl/regfile_write_buffer_if.sv | 27 ++
 rtl/regfile_write_buffer.sv | 96 +++++++++
 2 files changed

// File: rtl/regfile_write_buffer_if.sv
// Writeback request handshake into the register file write buffer.
// Master issues {register, data}; slave answers with ready.
interface regfile_write_buffer_if #(
  parameter int WordLen   = 32,
  parameter int WordCount = 32
);
  localparam int IdxW = $clog2(WordCount);

  logic            inValid;
  logic            inReady;
  logic [IdxW-1:0] inRegister;
  logic [WordLen-1:0] inData;

  modport master (
    output inValid,
    output inRegister,
    output inData,
    input  inReady
  );

  modport slave (
    input  inValid,
    input  inRegister,
    input  inData,
    output inReady
  );
endinterface

// File: rtl/regfile_write_buffer.sv
// In-order writeback FIFO feeding the register file write port,
// with two combinational forwarding lookups over pending writes.
module regfile_write_buffer #(
  parameter int WordLen   = 32,
  parameter int WordCount = 32,
  parameter int Depth     = 4
) (
  input  logic clk,
  input  logic rst_n,
  regfile_write_buffer_if.slave wb,
  input  logic hold,
  output logic regWrite,
  output logic [$clog2(WordCount)-1:0] writeRegister,
  output logic [WordLen-1:0] writeData,
  input  logic [$clog2(WordCount)-1:0] lookupRegister1,
  input  logic [$clog2(WordCount)-1:0] lookupRegister2,
  output logic lookupHit1,
  output logic lookupHit2,
  output logic [WordLen-1:0] lookupData1,
  output logic [WordLen-1:0] lookupData2,
  output logic [$clog2(Depth):0] pendingCount
);
  localparam int IdxW = $clog2(WordCount);
  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  logic [IdxW-1:0]    entReg  [Depth];
  logic [WordLen-1:0] entData [Depth];
  logic [PtrW-1:0]    rdPtr;
  logic [PtrW-1:0]    wrPtr;
  logic accept;
  logic push;
  logic pop;

  assign wb.inReady = (pendingCount != CntW'(Depth));
  assign accept = wb.inValid & wb.inReady;
  // x0 writes are consumed but never stored
  assign push = accept & (wb.inRegister != '0);
  assign pop  = (pendingCount != '0) & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr         <= '0;
      wrPtr         <= '0;
      pendingCount  <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      for (int i = 0; i < Depth; i++) begin
        entReg[i]  <= '0;
        entData[i] <= '0;
      end
    end else begin
      if (push) begin
        entReg[wrPtr]  <= wb.inRegister;
        entData[wrPtr] <= wb.inData;
        wrPtr          <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr         <= rdPtr + PtrW'(1);
        regWrite      <= 1'b1;
        writeRegister <= entReg[rdPtr];
        writeData     <= entData[rdPtr];
      end else begin
        regWrite <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   pendingCount <= pendingCount + CntW'(1);
        2'b01:   pendingCount <= pendingCount - CntW'(1);
        default: pendingCount <= pendingCount;
      endcase
    end
  end

  // Scan oldest to youngest so the last match is the youngest value
  function automatic logic [WordLen:0] lookup(
    input logic [IdxW-1:0] q
  );
    logic [WordLen:0] r;
    logic [PtrW-1:0]  p;
    r = '0;
    if (q != '0) begin
      if (regWrite && writeRegister == q)
        r = {1'b1, writeData};
      for (int i = 0; i < Depth; i++) begin
        p = rdPtr + PtrW'(i);
        if (CntW'(i) < pendingCount && entReg[p] == q)
          r = {1'b1, entData[p]};
      end
    end
    return r;
  endfunction

  assign {lookupHit1, lookupData1} = lookup(lookupRegister1);
  assign {lookupHit2, lookupData2} = lookup(lookupRegister2);
endmodule
